// File: rtl/usb_uart_tx_arbiter.sv
// usb_uart_tx_arbiter
//   Round-robin arbiter that merges NUM_REQ byte streams onto the single
//   device-to-host USB UART input pipe. A requester keeps the grant until it
//   has sent MAX_BURST bytes or drops its valid, whichever comes first. Only
//   the granted requester is ever acknowledged.
//
//   Build option: define USB_ARB_TAG_EN to prefix every grant with a tag byte
//   (8'hA0 | grant_id) so the host can demultiplex the stream. When undefined,
//   bursts go straight onto the pipe untagged.
//
// Ports
//   clk_48mhz      in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   req_data       in   [8*NUM_REQ] byte of requester i on [8i+7:8i]
//   req_valid      in   [NUM_REQ]   requester i offers a byte
//   req_ready      out  [NUM_REQ]   requester i's byte consumed this cycle
//   uart_in_data   out  [8]         byte towards the USB UART pipe
//   uart_in_valid  out              uart_in_data is valid
//   uart_in_ready  in               pipe accepts the byte this cycle
//   grant_id       out  [3]         granted requester, 0 when idle
//   busy           out              arbiter is not idle
module usb_uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                 clk_48mhz,
  input  logic                 reset_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef USB_ARB_TAG_EN
    S_TAG   = 2'd1,
`endif
    S_BURST = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX       = 8'(MAX_BURST);
  localparam logic [2:0] LP_LAST_INIT = 3'(NUM_REQ - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_grant;
  logic [2:0] r_last;
  logic [7:0] r_count;
  logic [2:0] w_next_grant;
  logic [2:0] w_next_last;
  logic [7:0] w_next_count;

  logic [2:0] w_pick;
  logic       w_any;
  logic [3:0] w_idx;
  logic       w_gvalid;
  logic [7:0] w_gdata;
  logic       w_beat;

  // Round-robin search: walk indices r_last+1, r_last+2, ... (mod NUM_REQ)
  // and take the first one that is valid. The inner loop turns the computed
  // index into a constant select so no out-of-range bit select is generated.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_last} + 4'(k);
      if (w_idx >= 4'(NUM_REQ)) begin
        w_idx = w_idx - 4'(NUM_REQ);
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_any && (w_idx == 4'(j)) && req_valid[j]) begin
          w_any  = 1'b1;
          w_pick = 3'(j);
        end
      end
    end
  end

  // Granted requester's valid/data, selected combinationally.
  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (r_grant == 3'(j)) begin
        w_gvalid = req_valid[j];
        w_gdata  = req_data[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= LP_LAST_INIT;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_grant <= w_next_grant;
      r_last  <= w_next_last;
      r_count <= w_next_count;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_next_grant  = r_grant;
    w_next_last   = r_last;
    w_next_count  = r_count;
    uart_in_data  = '0;
    uart_in_valid = 1'b0;
    req_ready     = '0;
    w_beat        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          // Pointer moves only here, so it advances exactly once per grant.
          w_next_grant = w_pick;
          w_next_last  = w_pick;
          w_next_count = '0;
`ifdef USB_ARB_TAG_EN
          w_next       = S_TAG;
`else
          w_next       = S_BURST;
`endif
        end
      end

`ifdef USB_ARB_TAG_EN
      S_TAG: begin
        uart_in_data  = 8'hA0 | {5'b0, r_grant};
        uart_in_valid = 1'b1;
        if (uart_in_ready) begin
          w_next       = S_BURST;
          w_next_count = '0;
        end
      end
`endif

      S_BURST: begin
        uart_in_data  = w_gdata;
        uart_in_valid = w_gvalid;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          req_ready[j] = (r_grant == 3'(j)) & uart_in_ready;
        end
        w_beat = w_gvalid & uart_in_ready;
        // Valid low and the final beat both lead to the same single exit.
        if (!w_gvalid) begin
          w_next       = S_IDLE;
          w_next_grant = '0;
        end else if (w_beat) begin
          if ((r_count + 8'd1) == LP_MAX) begin
            w_next       = S_IDLE;
            w_next_grant = '0;
          end else begin
            w_next_count = r_count + 8'd1;
          end
        end
      end

      default: begin
        w_next       = S_IDLE;
        w_next_grant = '0;
      end
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: doc/usb_uart_tx_arbiter.md
USB_UART_TX_ARBITER -- requirements
Module: usb_uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte-stream requesters sharing the USB UART device-to-host pipe; legal range 2..8.
REQ-002 Parameter MAX_BURST, default 64: maximum bytes accepted from one requester per grant; legal range 1..255.
REQ-003 clk_48mhz  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_data  input  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
REQ-006 req_valid  input  NUM_REQ  requester i offers a byte.
REQ-007 req_ready  output  NUM_REQ  requester i's byte is consumed this cycle.
REQ-008 uart_in_data  output  8  byte to the USB UART input pipe.
REQ-009 uart_in_valid  output  1  uart_in_data is valid.
REQ-010 uart_in_ready  input  1  USB UART pipe accepts the byte this cycle.
REQ-011 grant_id  output  3  index of the currently granted requester; 0 when idle.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, TAG (only with the configuration macro), and BURST.
REQ-014 In IDLE, if any req_valid bit is high, the block SHALL pick a requester round-robin, starting at the index after the last granted requester (wrapping NUM_REQ-1 to 0), and latch it into grant_id.
REQ-015 IDLE SHALL drive uart_in_valid=0 and req_ready=0; arbitration costs exactly one cycle (IDLE to TAG/BURST on the next edge).
REQ-016 In BURST, uart_in_data SHALL equal the granted requester's req_data, and uart_in_valid SHALL equal its req_valid, combinationally (zero latency).
REQ-017 In BURST, req_ready[grant_id] SHALL equal uart_in_ready; all other req_ready bits SHALL be 0.
REQ-018 A beat SHALL be counted when uart_in_valid and uart_in_ready are both high; the 8-bit beat counter SHALL clear on entry to BURST.
REQ-019 BURST SHALL return to IDLE after the beat that brings the count to MAX_BURST.
REQ-020 BURST SHALL also return to IDLE in any cycle where the granted req_valid is low; no beat occurs in that cycle.
REQ-021 When both exit conditions hold in the same cycle, the block SHALL take the single IDLE transition; the round-robin pointer SHALL advance exactly once per grant.
REQ-022 Requests from non-granted requesters SHALL never be acknowledged and SHALL not pre-empt a grant.
REQ-023 Back-pressure (uart_in_ready low) SHALL hold the current byte; it SHALL neither count nor end the burst.
REQ-024 A requester whose valid drops and later rises SHALL wait for normal round-robin re-arbitration.

Reset
REQ-025 On reset_n low, the block SHALL asynchronously enter IDLE with grant_id=0, beat counter=0 and round-robin pointer=NUM_REQ-1, so that requester 0 has first priority.
REQ-026 While reset is asserted, uart_in_valid, req_ready and busy SHALL be 0; a byte in flight when reset asserts is dropped, not replayed.
REQ-027 Release of reset_n SHALL take effect on the next clk_48mhz edge; the first possible grant is one cycle after release.

Configuration
REQ-028 Macro USB_ARB_TAG_EN: when defined, each grant SHALL go IDLE -> TAG -> BURST.
REQ-029 TAG SHALL drive uart_in_data = 8'hA0 | grant_id and uart_in_valid=1, and SHALL drive all req_ready bits to 0.
REQ-030 TAG SHALL hold until uart_in_ready is high; the tag byte is not counted toward MAX_BURST.
REQ-031 Without USB_ARB_TAG_EN, TAG SHALL not exist and IDLE SHALL go directly to BURST; the data stream is untagged.

Verification
REQ-032 Reset, then req_valid=4'b0001 holding 3 bytes 0x11,0x22,0x33, uart_in_ready=1 -> grant_id=0, uart_in_data sequence 0x11,0x22,0x33, then IDLE.
REQ-033 All four requesters hold continuous data, MAX_BURST=2 -> grant order 0,1,2,3,0, with exactly 2 bytes per grant.
REQ-034 Grant to requester 2, then uart_in_ready low for 5 cycles -> byte is held stable, req_ready[2]=0, beat count unchanged, grant retained.
REQ-035 Granted requester's valid drops on the same cycle as the MAX_BURST-th beat -> single return to IDLE; the next grant goes to the following index.
REQ-036 Assert reset_n low mid-burst -> outputs are 0 immediately (asynchronously); after release, requester 0 is granted first.
REQ-037 With USB_ARB_TAG_EN defined, requester 3 sends 0x55 with uart_in_ready=1 -> output sequence is 0xA3, then 0x55.
